// File: rtl/disp_ram_arbiter.sv
// Single-port arbiter for the banked spectrogram display RAM: posted STFT writes
// through a small FIFO, display reads via rd_req/rd_ack with a bounded read burst.
module disp_ram_arbiter #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int NO_BANKS      = 2,
    parameter int DATA_WIDTH    = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int MAX_RD_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [NO_BANKS-1:0]           wr_bank,
    input  logic [ADDRESS_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_req,
    input  logic [NO_BANKS-1:0]           rd_bank,
    input  logic [ADDRESS_WIDTH-1:0]      rd_addr,
    output logic                          rd_ack,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [NO_BANKS-1:0]           ram_ce,
    output logic                          ram_we,
    output logic [ADDRESS_WIDTH-1:0]      ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          wr_overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int BURST_W = $clog2(MAX_RD_BURST + 1);
    localparam int ENTRY_W = NO_BANKS + ADDRESS_WIDTH + DATA_WIDTH;

    localparam logic [LVL_W-1:0]   LVL_ALMOST = LVL_W'(FIFO_DEPTH - 1);
    localparam logic [LVL_W-1:0]   LVL_FULL   = LVL_W'(FIFO_DEPTH);
    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_RD_BURST);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

    state_t                     state_q, state_d;
    logic [ENTRY_W-1:0]         fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]           level_q, level_d;
    logic [BURST_W-1:0]         burst_q, burst_d;
    logic                       ovf_q, ovf_d;
    logic                       rd_valid_q;
    logic [NO_BANKS-1:0]        ram_ce_q, ram_ce_d;
    logic                       ram_we_q, ram_we_d;
    logic [ADDRESS_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]      ram_wdata_q, ram_wdata_d;

    logic                       fifo_nempty;
    logic                       pop;
    logic                       push_ok;
    logic                       rd_pend;
    logic [NO_BANKS-1:0]        head_bank;
    logic [ADDRESS_WIDTH-1:0]   head_addr;
    logic [DATA_WIDTH-1:0]      head_data;

    assign {head_bank, head_addr, head_data} = fifo_mem_q[rd_ptr_q];
    assign fifo_nempty = (level_q != '0);
    // A read issued last cycle is exactly the read-pending condition.
    assign rd_pend     = (state_q == S_RD);

    always_comb begin
        state_d     = S_IDLE;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        burst_d     = burst_q;
        ovf_d       = ovf_q;
        ram_ce_d    = '0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        pop         = 1'b0;
        push_ok     = 1'b0;

        if (level_q >= LVL_ALMOST) begin
            state_d = S_WR;
        end else if (fifo_nempty && (burst_q == BURST_MAX)) begin
            state_d = S_WR;
        end else if (rd_req) begin
            state_d = S_RD;
        end else if (fifo_nempty) begin
            state_d = S_WR;
        end

        case (state_d)
            S_WR: begin
                pop         = 1'b1;
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                ram_ce_d    = head_bank;
                ram_we_d    = 1'b1;
                ram_addr_d  = head_addr;
                ram_wdata_d = head_data;
            end
            S_RD: begin
                ram_ce_d    = rd_bank;
                ram_addr_d  = rd_addr;
            end
            default: ;
        endcase

        // A push into a full FIFO is only accepted when the head leaves this cycle.
        push_ok = wr_en && ((level_q != LVL_FULL) || pop);
        if (wr_en && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);

        if ((state_d == S_WR) || !fifo_nempty) begin
            burst_d = '0;
        end else if ((state_d == S_RD) && (burst_q != BURST_MAX)) begin
            burst_d = burst_q + BURST_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            burst_q     <= '0;
            ovf_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            ram_ce_q    <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            burst_q     <= burst_d;
            ovf_q       <= ovf_d;
            rd_valid_q  <= rd_pend;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= {wr_bank, wr_addr, wr_data};
        end
    end

    // rd_ack is combinational, so it is gated to stay low throughout reset.
    assign rd_ack      = (state_d == S_RD) && reset_n;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = ram_rdata;
    assign ram_ce      = ram_ce_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign fifo_level  = level_q;
    assign wr_overflow = ovf_q;

endmodule
